// File: rtl/nn_argmax_reader_if.sv
// Result-side bus of the argmax reader: neuron capture inputs plus the
// {class index, score} valid/ready result channel and status flags.
interface nn_argmax_reader_if #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IDX_WIDTH   = 4
);
  logic [NUM_CLASSES*DATA_WIDTH-1:0] layer_out;
  logic [NUM_CLASSES-1:0]            layer_valid;
  logic [IDX_WIDTH-1:0]              class_idx;
  logic [DATA_WIDTH-1:0]             class_val;
  logic                              result_valid;
  logic                              result_ready;
  logic                              busy;
  logic                              overrun;

  modport master (
    output layer_out, layer_valid, result_ready,
    input  class_idx, class_val, result_valid, busy, overrun
  );

  modport slave (
    input  layer_out, layer_valid, result_ready,
    output class_idx, class_val, result_valid, busy, overrun
  );
endinterface

// File: rtl/nn_argmax_reader.sv
// Captures per-neuron output words, scans them one per cycle for the signed
// maximum, and presents {class index, score} on a valid/ready handshake.
module nn_argmax_reader #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input logic               clk,
  input logic               rst,
  nn_argmax_reader_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StCollect, StScan, StHold} state_e;

  state_e                  r_state;
  logic [DATA_WIDTH-1:0]   r_slot [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]  r_flag;
  logic [IDX_WIDTH-1:0]    r_idx;
  logic [IDX_WIDTH-1:0]    r_best_idx;
  logic [DATA_WIDTH-1:0]   r_best_val;
  logic [IDX_WIDTH-1:0]    r_class_idx;
  logic [DATA_WIDTH-1:0]   r_class_val;
  logic                    r_result_valid;
  logic                    r_overrun;

  logic [DATA_WIDTH-1:0]   w_cand_val;
  logic [DATA_WIDTH-1:0]   w_next_val;
  logic [IDX_WIDTH-1:0]    w_next_idx;
  logic                    w_take;

  // Strict greater-than keeps the lowest index on ties; idx 0 always seeds the best.
  always_comb begin
    w_cand_val = r_slot[r_idx];
    w_take     = (r_idx == '0) || ($signed(w_cand_val) > $signed(r_best_val));
    w_next_val = w_take ? w_cand_val : r_best_val;
    w_next_idx = w_take ? r_idx : r_best_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StCollect;
      r_flag         <= '0;
      r_idx          <= '0;
      r_best_idx     <= '0;
      r_best_val     <= '0;
      r_class_idx    <= '0;
      r_class_val    <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      r_overrun <= 1'b0;
      unique case (r_state)
        StCollect: begin
          for (int k = 0; k < NUM_CLASSES; k++) begin
            if (bus.layer_valid[k]) begin
              r_slot[k] <= bus.layer_out[k*DATA_WIDTH +: DATA_WIDTH];
              r_flag[k] <= 1'b1;
            end
          end
          if (&(r_flag | bus.layer_valid)) begin
            r_state <= StScan;
            r_idx   <= '0;
          end
        end
        StScan: begin
          r_overrun  <= |bus.layer_valid;
          r_best_val <= w_next_val;
          r_best_idx <= w_next_idx;
          if (r_idx == LastIdx) begin
            r_class_val    <= w_next_val;
            r_class_idx    <= w_next_idx;
            r_result_valid <= 1'b1;
            r_state        <= StHold;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StHold: begin
          r_overrun <= |bus.layer_valid;
          if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            r_flag         <= '0;
            r_state        <= StCollect;
          end
        end
        default: r_state <= StCollect;
      endcase
    end
  end

  assign bus.class_idx    = r_class_idx;
  assign bus.class_val    = r_class_val;
  assign bus.result_valid = r_result_valid;
  assign bus.overrun      = r_overrun;
  assign bus.busy         = (r_state != StCollect);

endmodule

// File: tb/tb_nn_argmax_reader.sv
// Directed bench for nn_argmax_reader: hand-computed argmax results, latency,
// hold-stability, overrun pulses, async reset and back-to-back images.
module tb_nn_argmax_reader;

  localparam int NC = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic ovr_seen;
  logic pulse [5];

  always #5 clk = ~clk;

  nn_argmax_reader_if #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  nn_argmax_reader #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [DW-1:0] v);
    bus.layer_out[k*DW +: DW] = v;
  endtask

  // Call right after the capture edge; result must appear on the 10th edge.
  task automatic wait_result(input string tag);
    int cyc;
    cyc = 0;
    while (bus.result_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (bus.overrun === 1'b1) ovr_seen = 1'b1;
    end
    check(tag, cyc, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.layer_out    = '0;
    bus.layer_valid  = '0;
    bus.result_ready = 1'b0;
    ovr_seen         = 1'b0;
    #12;
    check("rst_valid", bus.result_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_idx", bus.class_idx, 0);
    check("rst_val", bus.class_val, 0);
    check("rst_ovr", bus.overrun, 0);
    rst = 1'b0;
    tick();

    // 1: all valids in one cycle, slot7 wins
    for (int k = 0; k < NC; k++) set_slot(k, 16'(k * 16'h0010));
    set_slot(7, 16'h0400);
    bus.layer_valid = '1;
    tick();
    bus.layer_valid = '0;
    check("t1_busy", bus.busy, 1);
    check("t1_rv_early", bus.result_valid, 0);
    wait_result("t1_latency");
    check("t1_idx", bus.class_idx, 7);
    check("t1_val", bus.class_val, 16'h0400);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("t1_rv_drop", bus.result_valid, 0);
    check("t1_busy_drop", bus.busy, 0);
    check("t1_idx_keep", bus.class_idx, 7);

    // 2: staggered 9..0, negative scores, signed compare
    for (int k = 0; k < NC; k++) set_slot(k, 16'(16'h8000 + k * 16'h0010));
    set_slot(3, 16'hFFFF);
    for (int k = NC - 1; k >= 0; k--) begin
      bus.layer_valid    = '0;
      bus.layer_valid[k] = 1'b1;
      tick();
      if (k == 5) check("t2_busy_partial", bus.busy, 0);
    end
    bus.layer_valid = '0;
    wait_result("t2_latency");
    check("t2_idx", bus.class_idx, 3);
    check("t2_val", bus.class_val, 16'hFFFF);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;

    // 3: tie resolves to lowest index
    for (int k = 0; k < NC; k++) set_slot(k, 16'(k));
    set_slot(2, 16'h7FFF);
    set_slot(5, 16'h7FFF);
    bus.layer_valid = '1;
    tick();
    bus.layer_valid = '0;
    wait_result("t3_latency");
    check("t3_idx", bus.class_idx, 2);
    check("t3_val", bus.class_val, 16'h7FFF);

    // 4: hold with ready low while valids pulse
    pulse[0] = 1'b1; pulse[1] = 1'b0; pulse[2] = 1'b1; pulse[3] = 1'b1; pulse[4] = 1'b0;
    for (int k = 0; k < NC; k++) set_slot(k, 16'h1111);
    for (int i = 0; i < 5; i++) begin
      bus.layer_valid = pulse[i] ? '1 : '0;
      tick();
      check($sformatf("t4_ovr%0d", i), bus.overrun, pulse[i]);
      check($sformatf("t4_rv%0d", i), bus.result_valid, 1);
      check($sformatf("t4_idx%0d", i), bus.class_idx, 2);
      check($sformatf("t4_val%0d", i), bus.class_val, 16'h7FFF);
    end
    bus.layer_valid  = '1;
    bus.result_ready = 1'b1;
    tick();
    bus.layer_valid  = '0;
    bus.result_ready = 1'b0;
    check("t4_hs_rv", bus.result_valid, 0);
    check("t4_hs_ovr", bus.overrun, 1);
    check("t4_hs_idx", bus.class_idx, 2);
    tick();
    check("t4_no_stale", bus.busy, 0);
    check("t4_ovr_clr", bus.overrun, 0);
    for (int k = 0; k < NC; k++) set_slot(k, 16'(16'h0100 - k));
    bus.layer_valid = '1;
    tick();
    bus.layer_valid = '0;
    wait_result("t4_latency");
    check("t4_idx", bus.class_idx, 0);
    check("t4_val", bus.class_val, 16'h0100);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;

    // 5: async reset at scan idx 4
    for (int k = 0; k < NC; k++) set_slot(k, 16'(k));
    set_slot(9, 16'h0F00);
    bus.layer_valid = '1;
    tick();
    bus.layer_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_busy_pre", bus.busy, 1);
    check("t5_val_pre", bus.class_val, 16'h0100);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_val", bus.class_val, 0);
    check("t5_rst_idx", bus.class_idx, 0);
    check("t5_rst_rv", bus.result_valid, 0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NC; k++) set_slot(k, 16'(k + 1));
    set_slot(5, 16'h1234);
    bus.layer_valid = 10'h1FF;
    tick();
    bus.layer_valid = '0;
    check("t5_partial_busy", bus.busy, 0);
    bus.layer_valid = 10'h200;
    tick();
    bus.layer_valid = '0;
    wait_result("t5_latency");
    check("t5_idx", bus.class_idx, 5);
    check("t5_val", bus.class_val, 16'h1234);

    // 6: back-to-back with ready tied high
    bus.result_ready = 1'b1;
    tick();
    ovr_seen = 1'b0;
    for (int k = 0; k < NC; k++) set_slot(k, 16'(k * 2));
    set_slot(8, 16'h0800);
    bus.layer_valid = '1;
    tick();
    bus.layer_valid = '0;
    wait_result("t6a_latency");
    check("t6a_idx", bus.class_idx, 8);
    check("t6a_val", bus.class_val, 16'h0800);
    tick();
    check("t6_hs_rv", bus.result_valid, 0);
    if (bus.overrun === 1'b1) ovr_seen = 1'b1;
    for (int k = 0; k < NC; k++) set_slot(k, 16'(16'hFFF0 + k));
    set_slot(1, 16'h0001);
    bus.layer_valid = '1;
    tick();
    bus.layer_valid = '0;
    if (bus.overrun === 1'b1) ovr_seen = 1'b1;
    wait_result("t6b_latency");
    check("t6b_idx", bus.class_idx, 1);
    check("t6b_val", bus.class_val, 16'h0001);
    check("t6_no_overrun", ovr_seen, 0);
    tick();
    bus.result_ready = 1'b0;
    check("t6_end_rv", bus.result_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
